// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared types and constants for the packet-aware 1-to-2 stream demux.
//
//   route_state_e : packet routing FSM state
//                   ST_IDLE  - between packets, route follows in_sel
//                   ST_ROUTE - inside a packet, route is locked
//   CH_A / CH_B   : encoding of the destination select (in_sel / locked_sel)
// -----------------------------------------------------------------------------
package demux_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ROUTE = 1'b1
   } route_state_e;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_1_to_2_hold_stage.sv
// -----------------------------------------------------------------------------
// hold_stage
//   One-entry registered output stage with a valid/ready handshake on the
//   downstream side. A load writes data/last and raises valid one cycle later.
//   A handshake (valid && ready) without a new load empties the stage; a load
//   in the same cycle as a handshake refills it, so a beat can move through
//   every cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active high
//   load_i   in   write data_i/last_i into the stage this cycle
//   data_i   in   beat payload to load
//   last_i   in   end-of-packet flag to load
//   ready_i  in   downstream consumer ready
//   valid_o  out  stage holds a beat
//   data_o   out  held payload (stable while valid_o && !ready_i)
//   last_o   out  held end-of-packet flag
// -----------------------------------------------------------------------------
module hold_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  last_q,  last_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the payload registers are reset as well, not just valid, so
         // the outputs read as zero after reset rather than stale data.
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state, so every register
         // samples the pre-edge values regardless of statement order.
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule : hold_stage

// File: rtl/demux_1_to_2.sv
// -----------------------------------------------------------------------------
// demux_1_to_2
//   Packet-aware 1-to-2 valid/ready stream demultiplexer. The destination is
//   taken from in_sel on the first beat of a packet and held until the beat
//   carrying in_last is accepted, so a packet never splits across channels
//   and per-channel beat order is preserved. Each output has a one-entry
//   registered stage (latency 1, throughput 1 beat/cycle). The stage that is
//   not the current target keeps draining on its own.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active high (drops held beats and
//                     any locked route)
//   in_data      in   input beat payload
//   in_valid     in   input beat offered
//   in_last      in   input beat is the final beat of its packet
//   in_sel       in   destination 0 -> a, 1 -> b (first beat only)
//   in_ready     out  input beat accepted when in_valid && in_ready
//   out_a_data   out  channel a payload
//   out_a_last   out  channel a end-of-packet
//   out_a_valid  out  channel a beat offered
//   out_a_ready  in   channel a consumer ready
//   out_b_data   out  channel b payload
//   out_b_last   out  channel b end-of-packet
//   out_b_valid  out  channel b beat offered
//   out_b_ready  in   channel b consumer ready
// -----------------------------------------------------------------------------
module demux_1_to_2
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic                  in_sel,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_a_data,
   output logic                  out_a_last,
   output logic                  out_a_valid,
   input  logic                  out_a_ready,
   output logic [DATA_WIDTH-1:0] out_b_data,
   output logic                  out_b_last,
   output logic                  out_b_valid,
   input  logic                  out_b_ready
);

   route_state_e state_q, state_d;
   logic         locked_sel_q, locked_sel_d;

   logic target;
   logic accept;
   logic load_a, load_b;
   logic a_valid, b_valid;

   // Destination of the beat currently offered: free choice between packets,
   // locked choice inside one.
   assign target = (state_q == ST_ROUTE) ? locked_sel_q : in_sel;

   // A stage can take a beat when it is empty or is emptying this cycle.
   // Deliberately independent of in_valid so upstream may wait on in_ready.
   assign in_ready = (target == CH_A) ? (!a_valid || out_a_ready)
                                      : (!b_valid || out_b_ready);

   assign accept = in_valid && in_ready;
   assign load_a = accept && (target == CH_A);
   assign load_b = accept && (target == CH_B);

   // Routing FSM: next state and locked route.
   always_comb begin
      state_d      = state_q;
      locked_sel_d = locked_sel_q;
      unique case (state_q)
         ST_IDLE: begin
            // A single-beat packet (in_last on the first beat) never locks.
            if (accept && !in_last) begin
               state_d      = ST_ROUTE;
               locked_sel_d = in_sel;
            end
         end
         ST_ROUTE: begin
            if (accept && in_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         locked_sel_q <= CH_A;
      end else begin
         state_q      <= state_d;
         locked_sel_q <= locked_sel_d;
      end
   end

   hold_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_a (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_a),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_a_ready),
      .valid_o (a_valid),
      .data_o  (out_a_data),
      .last_o  (out_a_last)
   );

   hold_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_b (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_b),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_b_ready),
      .valid_o (b_valid),
      .data_o  (out_b_data),
      .last_o  (out_b_last)
   );

   assign out_a_valid = a_valid;
   assign out_b_valid = b_valid;

endmodule : demux_1_to_2

// File: tb/tb_demux_1_to_2.sv
// -----------------------------------------------------------------------------
// tb_demux_1_to_2
//   Scoreboard bench for demux_1_to_2. Each accepted input beat is pushed to
//   the queue of the channel a reference routing model picks; every output
//   handshake pops and compares against that queue.
// -----------------------------------------------------------------------------
module tb_demux_1_to_2;
   import demux_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_sel;
   logic          in_ready;
   logic [DW-1:0] out_a_data;
   logic          out_a_last;
   logic          out_a_valid;
   logic          out_a_ready;
   logic [DW-1:0] out_b_data;
   logic          out_b_last;
   logic          out_b_valid;
   logic          out_b_ready;

   demux_1_to_2 #(
      .DATA_WIDTH (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_sel      (in_sel),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_a_last  (out_a_last),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_last  (out_b_last),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Expected beats per channel: {last, data}.
   logic [DW:0] q_a[$];
   logic [DW:0] q_b[$];
   int          cnt_b = 0;

   // Reference routing model.
   logic m_busy = 1'b0;
   logic m_lock = 1'b0;
   logic rand_on = 1'b0;

   // Output monitor: inputs only change just after a rising edge, so the
   // handshake seen at the falling edge is the one the next edge completes.
   always @(negedge clk) begin
      logic [DW:0] e;
      if (rst) begin
         q_a.delete();
         q_b.delete();
      end else begin
         if (out_a_valid && out_a_ready) begin
            if (q_a.size() == 0) begin
               check("a_extra_beat", 32'(out_a_data), 32'hFFFF_FFFF);
            end else begin
               e = q_a.pop_front();
               check("a_data", 32'(out_a_data), 32'(e[DW-1:0]));
               check("a_last", 32'(out_a_last), 32'(e[DW]));
            end
         end
         if (out_b_valid && out_b_ready) begin
            cnt_b++;
            if (q_b.size() == 0) begin
               check("b_extra_beat", 32'(out_b_data), 32'hFFFF_FFFF);
            end else begin
               e = q_b.pop_front();
               check("b_data", 32'(out_b_data), 32'(e[DW-1:0]));
               check("b_last", 32'(out_b_last), 32'(e[DW]));
            end
         end
      end
   end

   // Offer one beat and hold it until accepted; returns the cycles it took.
   task automatic send(input logic [DW-1:0] d, input logic l, input logic s, output int cyc);
      logic acc;
      logic tgt;
      in_data  = d;
      in_last  = l;
      in_sel   = s;
      in_valid = 1'b1;
      acc      = 1'b0;
      cyc      = 0;
      while (!acc && cyc < 200) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            tgt = m_busy ? m_lock : s;
            if (!m_busy && !l) begin
               m_busy = 1'b1;
               m_lock = s;
            end else if (m_busy && l) begin
               m_busy = 1'b0;
            end
            if (tgt == CH_A) q_a.push_back({l, d});
            else             q_b.push_back({l, d});
         end
         @(posedge clk);
         #1;
         cyc++;
         if (rand_on) begin
            out_a_ready = 1'($urandom_range(0, 1));
            out_b_ready = 1'($urandom_range(0, 1));
         end
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (q_a.size() == 0 && q_b.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_left", 32'(q_a.size() + q_b.size()), 32'd0);
   endtask

   initial begin
      int c;
      int n_valid;
      int b_before;

      rst = 1'b1;
      in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0;
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      check("rst_a_valid", 32'(out_a_valid), 32'd0);
      check("rst_b_valid", 32'(out_b_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

      // 1. Reset mid-packet: stage a full, FSM locked.
      send(8'h55, 1'b0, CH_A, c);
      check("t1_a_full", 32'(out_a_valid), 32'd1);
      check("t1_state_route", 32'(dut.state_q), 32'(ST_ROUTE));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_busy = 1'b0;
      check("t1_a_valid", 32'(out_a_valid), 32'd0);
      check("t1_b_valid", 32'(out_b_valid), 32'd0);
      check("t1_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      check("t1_a_data", 32'(out_a_data), 32'd0);

      // 2. Single beat to b, one cycle latency.
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      send(8'hA5, 1'b1, CH_B, c);
      check("t2_b_valid", 32'(out_b_valid), 32'd1);
      check("t2_b_data", 32'(out_b_data), 32'hA5);
      check("t2_a_valid", 32'(out_a_valid), 32'd0);
      check("t2_state", 32'(dut.state_q), 32'(ST_IDLE));
      wait_drain();

      // 3. Sel lock: sel toggles mid-packet, all beats stay on a.
      b_before = cnt_b;
      send(8'h01, 1'b0, CH_A, c);
      send(8'h02, 1'b0, CH_B, c);
      send(8'h03, 1'b1, CH_B, c);
      wait_drain();
      check("t3_b_untouched", 32'(cnt_b), 32'(b_before));

      // 4. Backpressure on a.
      out_a_ready = 1'b0;
      send(8'h10, 1'b1, CH_A, c);
      in_sel = CH_A;
      check("t4_ready_idle_in", 32'(in_ready), 32'd0);
      in_data  = 8'h20;
      in_last  = 1'b0;
      in_valid = 1'b1;
      #1;
      check("t4_ready_valid_in", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_hold_valid", 32'(out_a_valid), 32'd1);
      check("t4_hold_data", 32'(out_a_data), 32'h10);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      in_sel = CH_B;
      #1;
      check("t4_b_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_sel   = CH_A;
      out_a_ready = 1'b1;
      send(8'h20, 1'b0, CH_A, c);
      check("t4_release_cyc", 32'(c), 32'd1);
      send(8'h21, 1'b0, CH_A, c);
      send(8'h22, 1'b1, CH_A, c);
      wait_drain();

      // 5. Streaming: 16 beats, one per cycle, a valid every cycle.
      n_valid = 0;
      for (int i = 0; i < 16; i++) begin
         send(DW'(8'h40 + i), (i == 15), CH_A, c);
         if (c == 1 && out_a_valid) n_valid++;
      end
      check("t5_stream_cycles", 32'(n_valid), 32'd16);
      wait_drain();

      // 6. Independence: a stalled with 8'h11 while a packet crosses b.
      out_a_ready = 1'b0;
      send(8'h11, 1'b1, CH_A, c);
      send(8'h30, 1'b0, CH_B, c);
      send(8'h31, 1'b0, CH_A, c);
      send(8'h32, 1'b1, CH_B, c);
      repeat (3) @(posedge clk);
      #1;
      check("t6_b_done", 32'(q_b.size()), 32'd0);
      check("t6_a_valid", 32'(out_a_valid), 32'd1);
      check("t6_a_data", 32'(out_a_data), 32'h11);
      out_a_ready = 1'b1;
      wait_drain();

      // Random traffic with random backpressure on both channels.
      rand_on = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send(DW'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), c);
      end
      rand_on = 1'b0;
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux_1_to_2
